pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencing and hazard controller for the five-stage MIPS pipeline. It owns the clock enables and bubble/flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It runs the debug-unit commands (run, single-step, stop), inserts load-use stalls, flushes the fetch slot on taken branches, and drains the pipeline after a HALT instruction. It sits beside the stage registers at top level, between the debug unit and the datapath.

## Interface
- Parameters: none; state encodings and widths come from the shared package.
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- cmd_run  in  1  debug unit: free-run request, single-cycle pulse
- cmd_step  in  1  debug unit: advance exactly one cycle, pulse
- cmd_stop  in  1  debug unit: pause free-run, pulse
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_branch_taken  in  1  branch resolved taken in ID
- id_halt  in  1  HALT decoded in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  load destination in EX
- wb_halt  in  1  HALT has reached WB
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register clock enables
- if_id_flush  out  1  IF_ID loads a NOP on its next enabled edge
- id_ex_bubble  out  1  ID_EX loads all-zero control (bubble)
- state  out  3  current FSM state, for the debug unit
- done  out  1  registered; high while in HALTED
- step_done  out  1  registered; one-cycle pulse after a STEP cycle
- cycle_count  out  32  active cycles executed, saturating

## Operation
- The FSM has five states: IDLE(0), RUN(1), STEP(2), DRAIN(3), HALTED(4).
- IDLE:
  - All enables 0.
  - cmd_run goes to RUN. Otherwise cmd_step goes to STEP. run beats step when both are present.
- RUN:
  - Stage enables follow the hazard rules below.
  - An accepted id_halt goes to DRAIN. Otherwise cmd_stop goes to IDLE.
  - If id_halt and cmd_stop arrive together, DRAIN wins.
- STEP:
  - Exactly one active cycle, same rules as RUN.
  - Next state is DRAIN if id_halt is accepted, else IDLE.
  - step_done pulses on the following cycle.
- DRAIN:
  - pc_en=0, if_id_en=0.
  - id_ex_en=1 with id_ex_bubble=1.
  - ex_mem_en=1, mem_wb_en=1.
  - wb_halt goes to HALTED.
  - Commands are ignored.
- HALTED: all enables 0, done=1. Only reset leaves this state.
- Load-use stall, evaluated only in RUN/STEP:
  - Condition: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
  - Action: pc_en=0, if_id_en=0, id_ex_bubble=1. id_ex_en, ex_mem_en and mem_wb_en stay 1.
- Priority when a stall occurs:
  - The stall suppresses if_id_flush.
  - id_halt is not accepted while stalled; it is re-evaluated the next cycle.
- Branch flush: id_branch_taken && !stall sets if_id_flush=1, with all enables 1.
- Normal active cycle (no hazard): all enables 1, flush 0, bubble 0.
- cycle_count:
  - Increments by 1 every cycle spent in RUN, STEP or DRAIN.
  - Saturates at 32'hFFFF_FFFF, with no wrap.
  - Holds its value in IDLE and HALTED.

## Timing
- Reset values: state=IDLE, cycle_count=0. Every output is 0, including all enables, flush, bubble, done and step_done.
- Reset asserted mid-operation (including mid-DRAIN) returns to IDLE immediately and asynchronously. A pending step_done is dropped.
- Enables, if_id_flush and id_ex_bubble are combinational from the registered state plus the current hazard inputs. They act on the same clock edge.
- A command sampled at edge N changes state at N. The new enables apply during cycle N..N+1.
- cmd_stop in RUN: the cycle in which it is sampled still runs. The FSM is IDLE from the next edge.
- step_done and done are registered, one cycle after the state event that causes them.
- Drain length: a HALT accepted in ID reaches WB 3 edges later, so DRAIN lasts 3 cycles when there are no external delays.

## Structure
- Shared package pipeline_pkg holds:
  - state localparams ST_IDLE..ST_HALTED, 3 bits;
  - REG_ADDR_W=5;
  - CYCLE_CNT_W=32.
- Sub-module hazard_detect (combinational) produces the load-use stall signal. pipeline_ctrl holds the FSM, the enable decode, the step_done/done registers and the counter.

## Test plan
- Reset, then cmd_step ×3, one per 4 cycles:
  - each step gives exactly one cycle with all enables 1, then step_done pulses;
  - cycle_count=3;
  - state is IDLE between steps.
- RUN, with ex_mem_read=1, ex_rt=5, id_rs=5: pc_en=0, if_id_en=0, id_ex_bubble=1, id_ex_en=1. The same stimulus with ex_rt=0 causes no stall.
- RUN with id_branch_taken=1 and no stall gives if_id_flush=1. Adding the load-use condition gives if_id_flush=0 plus a stall.
- RUN with id_halt=1 and cmd_stop=1 together:
  - next state is DRAIN, with pc_en=0 and id_ex_bubble=1;
  - wb_halt is raised 3 cycles later, then HALTED, with done=1 one cycle after;
  - cmd_run is ignored afterwards.
- Reset asserted during DRAIN gives state=IDLE and all outputs 0 immediately. A subsequent cmd_run resumes from IDLE with cycle_count starting from 0.
- Force cycle_count to 32'hFFFF_FFFE, then RUN for 5 cycles: the count stays at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings and widths for the five-stage pipeline controller.
package pipeline_pkg;

  localparam int STATE_W     = 3;
  localparam int REG_ADDR_W  = 5;
  localparam int CYCLE_CNT_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [CYCLE_CNT_W-1:0] CYCLE_CNT_MAX = {CYCLE_CNT_W{1'b1}};
  localparam logic [CYCLE_CNT_W-1:0] CYCLE_CNT_ONE = {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};

  // States in which the pipeline advances and cycles are counted
  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard detector: a load in EX feeding a source of ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  output logic                  o_stall
);

  logic w_rs_hit;
  logic w_rt_hit;

  // $zero is never a real dependency, so a load targeting it cannot stall
  assign w_rs_hit = (i_ex_rt == i_id_rs);
  assign w_rt_hit = i_id_uses_rt && (i_ex_rt == i_id_rt);
  assign o_stall  = i_ex_mem_read && (i_ex_rt != {REG_ADDR_W{1'b0}}) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing FSM: debug commands, stage enables, hazards, HALT drain, cycle counter.
module pipeline_ctrl
  import pipeline_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_cmd_run,
  input  logic                   i_cmd_step,
  input  logic                   i_cmd_stop,
  input  logic [REG_ADDR_W-1:0]  i_id_rs,
  input  logic [REG_ADDR_W-1:0]  i_id_rt,
  input  logic                   i_id_uses_rt,
  input  logic                   i_id_branch_taken,
  input  logic                   i_id_halt,
  input  logic                   i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  i_ex_rt,
  input  logic                   i_wb_halt,
  output logic                   o_pc_en,
  output logic                   o_if_id_en,
  output logic                   o_id_ex_en,
  output logic                   o_ex_mem_en,
  output logic                   o_mem_wb_en,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_bubble,
  output logic [STATE_W-1:0]     o_state,
  output logic                   o_done,
  output logic                   o_step_done,
  output logic [CYCLE_CNT_W-1:0] o_cycle_count
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_done;
  logic                   r_step_done;
  logic [CYCLE_CNT_W-1:0] r_cycle_count;
  logic                   w_stall;
  logic                   w_halt_acc;

  hazard_detect u_hazard_detect (
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt       (i_ex_rt),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_uses_rt  (i_id_uses_rt),
    .o_stall       (w_stall)
  );

  // A HALT stuck behind a load-use stall is retried once the stall clears
  assign w_halt_acc = i_id_halt && !w_stall;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and stage-control decode
  always_comb begin
    w_state_nxt    = r_state;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_id_ex_en     = 1'b0;
    o_ex_mem_en    = 1'b0;
    o_mem_wb_en    = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_run) begin
          w_state_nxt = ST_RUN;
        end else if (i_cmd_step) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        o_id_ex_en  = 1'b1;
        o_ex_mem_en = 1'b1;
        o_mem_wb_en = 1'b1;
        if (w_stall) begin
          o_id_ex_bubble = 1'b1;
        end else begin
          o_pc_en       = 1'b1;
          o_if_id_en    = 1'b1;
          o_if_id_flush = i_id_branch_taken;
        end
        if (w_halt_acc) begin
          w_state_nxt = ST_DRAIN;
        end else if ((r_state == ST_STEP) || i_cmd_stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Fetch is frozen; bubbles push the HALT and older work towards WB
        o_id_ex_en     = 1'b1;
        o_id_ex_bubble = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        if (i_wb_halt) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status flags lag the state they report by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_done      <= (r_state == ST_HALTED);
      r_step_done <= (r_state == ST_STEP);
    end
  end

  // Saturating active-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count <= {CYCLE_CNT_W{1'b0}};
    end else if (is_active(r_state) && (r_cycle_count != CYCLE_CNT_MAX)) begin
      r_cycle_count <= r_cycle_count + CYCLE_CNT_ONE;
    end else begin
      r_cycle_count <= r_cycle_count;
    end
  end

  assign o_state       = r_state;
  assign o_done        = r_done;
  assign o_step_done   = r_step_done;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard vector table plus step, drain, reset and saturation sequences.
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        cmd_run, cmd_step, cmd_stop;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_branch_taken, id_halt, ex_mem_read, wb_halt;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;
  logic [2:0]  state;
  logic        done, step_done;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_NORM  = 7'b1111100;
  localparam logic [6:0] O_FLUSH = 7'b1111110;
  localparam logic [6:0] O_STALL = 7'b0011101;
  localparam logic [6:0] O_DRAIN = 7'b0011101;

  typedef struct packed {
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [10];

  pipeline_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .i_cmd_run         (cmd_run),
    .i_cmd_step        (cmd_step),
    .i_cmd_stop        (cmd_stop),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_uses_rt      (id_uses_rt),
    .i_id_branch_taken (id_branch_taken),
    .i_id_halt         (id_halt),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_rt           (ex_rt),
    .i_wb_halt         (wb_halt),
    .o_pc_en           (pc_en),
    .o_if_id_en        (if_id_en),
    .o_id_ex_en        (id_ex_en),
    .o_ex_mem_en       (ex_mem_en),
    .o_mem_wb_en       (mem_wb_en),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_bubble    (id_ex_bubble),
    .o_state           (state),
    .o_done            (done),
    .o_step_done       (step_done),
    .o_cycle_count     (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [6:0] exp);
    check(name, {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble},
          {25'd0, exp});
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_hazards();
    ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rt = 1'b0; id_branch_taken = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, O_NORM};
    vecs[1] = '{1'b1, 5'd5, 5'd5,  5'd0,  1'b0, 1'b0, O_STALL};
    vecs[2] = '{1'b1, 5'd0, 5'd5,  5'd0,  1'b0, 1'b0, O_NORM};
    vecs[3] = '{1'b1, 5'd0, 5'd0,  5'd0,  1'b1, 1'b0, O_NORM};
    vecs[4] = '{1'b1, 5'd7, 5'd3,  5'd7,  1'b1, 1'b0, O_STALL};
    vecs[5] = '{1'b1, 5'd7, 5'd3,  5'd7,  1'b0, 1'b0, O_NORM};
    vecs[6] = '{1'b0, 5'd5, 5'd5,  5'd5,  1'b1, 1'b0, O_NORM};
    vecs[7] = '{1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, O_FLUSH};
    vecs[8] = '{1'b1, 5'd5, 5'd5,  5'd0,  1'b0, 1'b1, O_STALL};
    vecs[9] = '{1'b1, 5'd9, 5'd8,  5'd10, 1'b1, 1'b1, O_FLUSH};

    reset = 1'b1;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
    id_halt = 1'b0; wb_halt = 1'b0;
    clear_hazards();
    #2;
    check("reset_state", {29'd0, state}, 32'd0);
    check_outs("reset_outs", O_IDLE);
    check("reset_count", cycle_count, 32'd0);
    check("reset_flags", {30'd0, done, step_done}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;

    // Three single steps, four cycles apart
    for (int s = 0; s < 3; s++) begin
      cyc(); cmd_step = 1'b1; #2;
      check("step_pre_idle", {29'd0, state}, 32'd0);
      cyc(); cmd_step = 1'b0; #2;
      check("step_state", {29'd0, state}, 32'd2);
      check_outs("step_outs", O_NORM);
      check("step_done_early", {31'd0, step_done}, 32'd0);
      cyc(); #2;
      check("step_back_idle", {29'd0, state}, 32'd0);
      check_outs("step_idle_outs", O_IDLE);
      check("step_done_pulse", {31'd0, step_done}, 32'd1);
      cyc(); #2;
      check("step_done_clear", {31'd0, step_done}, 32'd0);
    end
    check("step_count", cycle_count, 32'd3);

    // Enter RUN and walk the hazard vector table
    cyc(); cmd_run = 1'b1;
    cyc(); cmd_run = 1'b0; #2;
    check("run_state", {29'd0, state}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      ex_mem_read = vecs[i].mem_read; ex_rt = vecs[i].ex_rt;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rt = vecs[i].uses_rt; id_branch_taken = vecs[i].branch;
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
      check($sformatf("vec%0d_state", i), {29'd0, state}, 32'd1);
    end

    // HALT is held off by a stall, then wins over a coincident stop
    cyc(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
    id_uses_rt = 1'b0; id_branch_taken = 1'b0; id_halt = 1'b1; #2;
    check_outs("halt_stall_outs", O_STALL);
    cyc(); #2;
    check("halt_stalled_state", {29'd0, state}, 32'd1);
    clear_hazards(); cmd_stop = 1'b1; #1;
    check_outs("halt_stop_outs", O_NORM);
    cyc(); id_halt = 1'b0; cmd_stop = 1'b0; cmd_run = 1'b1; #2;
    check("drain_state1", {29'd0, state}, 32'd3);
    check_outs("drain_outs", O_DRAIN);
    cyc(); #2;
    check("drain_state2", {29'd0, state}, 32'd3);
    cyc(); cmd_run = 1'b0; wb_halt = 1'b1; #2;
    check("drain_state3", {29'd0, state}, 32'd3);
    cyc(); wb_halt = 1'b0; #2;
    check("halted_state", {29'd0, state}, 32'd4);
    check_outs("halted_outs", O_IDLE);
    check("done_lag", {31'd0, done}, 32'd0);
    cyc(); cmd_run = 1'b1; #2;
    check("done_set", {31'd0, done}, 32'd1);
    cyc(); cmd_run = 1'b0; #2;
    check("halted_ignores_run", {29'd0, state}, 32'd4);
    check("halted_done_hold", {31'd0, done}, 32'd1);

    // Asynchronous reset in the middle of a drain
    reset = 1'b1; #1; reset = 1'b0;
    cyc(); cmd_run = 1'b1;
    cyc(); cmd_run = 1'b0; id_halt = 1'b1;
    cyc(); id_halt = 1'b0; #2;
    check("redrain_state", {29'd0, state}, 32'd3);
    #1; reset = 1'b1; #1;
    check("arst_state", {29'd0, state}, 32'd0);
    check_outs("arst_outs", O_IDLE);
    check("arst_count", cycle_count, 32'd0);
    check("arst_flags", {30'd0, done, step_done}, 32'd0);
    cyc(); reset = 1'b0; cmd_run = 1'b1; #2;
    check("post_arst_idle", {29'd0, state}, 32'd0);
    cyc(); cmd_run = 1'b0; #2;
    check("post_arst_run", {29'd0, state}, 32'd1);
    check("post_arst_count0", cycle_count, 32'd0);
    cyc(); #2;
    check("post_arst_count1", cycle_count, 32'd1);

    // Counter saturation
    cyc(); cmd_stop = 1'b1;
    cyc(); cmd_stop = 1'b0; #2;
    check("stop_idle", {29'd0, state}, 32'd0);
    force dut.r_cycle_count = 32'hFFFF_FFFE;
    cyc(); release dut.r_cycle_count; #2;
    check("sat_preload", cycle_count, 32'hFFFF_FFFE);
    cmd_run = 1'b1;
    cyc(); cmd_run = 1'b0; #2;
    check("sat_run_entry", cycle_count, 32'hFFFF_FFFE);
    for (int k = 0; k < 5; k++) begin
      cyc(); #2;
      check($sformatf("sat_cycle%0d", k), cycle_count, 32'hFFFF_FFFF);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
